dcache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller between the pipeline's load/store port and a multi-cycle backing data memory.
- Owns the valid/tag/data arrays and sequences refills and write-throughs over a req/ack memory handshake.
- Stalls the pipeline through a ready/valid CPU handshake.
- Provides a sequential flush (invalidate-all) and hit/miss counters for performance measurement.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_line_array.sv | 61 ++++++
 rtl/dcache_controller.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, default widths and address-split helpers for the direct-mapped
// write-through data cache.
package dcache_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH        = 32;
  localparam int unsigned DEF_SET_WIDTH         = 8;
  localparam int unsigned DEF_BYTE_OFFSET_WIDTH = 2;
  localparam int unsigned DEF_CNT_WIDTH         = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  // Callers zero-extend the address to 64 bits and truncate the result to their own width.
  function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                             input int unsigned set_w,
                                             input int unsigned off_w);
    logic [63:0] mask;
    mask = (64'd1 << set_w) - 64'd1;
    return (addr >> off_w) & mask;
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                           input int unsigned set_w,
                                           input int unsigned off_w);
    return addr >> (set_w + off_w);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one word per line,
// combinational lookup, only the valid bits are reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned SET_WIDTH  = DEF_SET_WIDTH,
  parameter int unsigned TAG_WIDTH  = DEF_ADDRESS_WIDTH - DEF_SET_WIDTH - DEF_BYTE_OFFSET_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SET_WIDTH-1:0]  rd_idx_i,
  input  logic [TAG_WIDTH-1:0]  rd_tag_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  fill_en_i,
  input  logic [SET_WIDTH-1:0]  fill_idx_i,
  input  logic [TAG_WIDTH-1:0]  fill_tag_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  wr_en_i,
  input  logic [SET_WIDTH-1:0]  wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  clr_en_i,
  input  logic [SET_WIDTH-1:0]  clr_idx_i
);

  localparam int unsigned NUM_LINES = 2 ** SET_WIDTH;

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  valid_d;
  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

  // A fill wins over a clear of the same line; the controller never issues both at once.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    assign valid_d[gi] = (fill_en_i && (fill_idx_i == SET_WIDTH'(gi))) ? 1'b1 :
                         (clr_en_i  && (clr_idx_i  == SET_WIDTH'(gi))) ? 1'b0 :
                         valid_q[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_mem[fill_idx_i]  <= fill_tag_i;
      data_mem[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_mem[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// req/ack backing memory, sequential flush and load hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned SET_WIDTH         = DEF_SET_WIDTH,
  parameter int unsigned BYTE_OFFSET_WIDTH = DEF_BYTE_OFFSET_WIDTH,
  parameter int unsigned TAG_WIDTH         = ADDRESS_WIDTH - SET_WIDTH - BYTE_OFFSET_WIDTH,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_valid_i,
  output logic                     cpu_ready_o,
  input  logic                     cpu_we_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  input  logic                     flush_i,
  output logic                     flush_busy_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic [CNT_WIDTH-1:0]     hit_count_o,
  output logic [CNT_WIDTH-1:0]     miss_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [SET_WIDTH-1:0] IDX_ONE  = SET_WIDTH'(1);
  localparam logic [SET_WIDTH-1:0] IDX_LAST = '1;

  state_e                   state_q, state_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]     miss_cnt_q, miss_cnt_d;
  logic [SET_WIDTH-1:0]     flush_idx_q, flush_idx_d;
  logic                     flush_busy_q, flush_busy_d;

  logic [SET_WIDTH-1:0]     cpu_idx, line_idx;
  logic [TAG_WIDTH-1:0]     cpu_tag, line_tag;
  logic [ADDRESS_WIDTH-1:0] cpu_word_addr;
  logic                     arr_hit;
  logic [DATA_WIDTH-1:0]    arr_rdata;
  logic                     fill_en, wr_en, clr_en;

  assign cpu_idx  = SET_WIDTH'(addr_index(64'(cpu_addr_i), SET_WIDTH, BYTE_OFFSET_WIDTH));
  assign cpu_tag  = TAG_WIDTH'(addr_tag(64'(cpu_addr_i), SET_WIDTH, BYTE_OFFSET_WIDTH));
  // The outstanding miss is refilled from the latched memory address, not the live CPU bus.
  assign line_idx = SET_WIDTH'(addr_index(64'(mem_addr_q), SET_WIDTH, BYTE_OFFSET_WIDTH));
  assign line_tag = TAG_WIDTH'(addr_tag(64'(mem_addr_q), SET_WIDTH, BYTE_OFFSET_WIDTH));
  assign cpu_word_addr = {cpu_addr_i[ADDRESS_WIDTH-1:BYTE_OFFSET_WIDTH], {BYTE_OFFSET_WIDTH{1'b0}}};

  assign cpu_ready_o = (state_q == ST_IDLE) && !flush_i;

  dcache_line_array #(
    .SET_WIDTH  (SET_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lines (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_idx_i    (cpu_idx),
    .rd_tag_i    (cpu_tag),
    .hit_o       (arr_hit),
    .rd_data_o   (arr_rdata),
    .fill_en_i   (fill_en),
    .fill_idx_i  (line_idx),
    .fill_tag_i  (line_tag),
    .fill_data_i (mem_rdata_i),
    .wr_en_i     (wr_en),
    .wr_idx_i    (cpu_idx),
    .wr_data_i   (cpu_wdata_i),
    .clr_en_i    (clr_en),
    .clr_idx_i   (flush_idx_q)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_idx_d  = flush_idx_q;
    flush_busy_d = flush_busy_q;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    clr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d      = ST_FLUSH;
          flush_idx_d  = '0;
          flush_busy_d = 1'b1;
        end else if (cpu_valid_i) begin
          if (!cpu_we_i && arr_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = arr_rdata;
            hit_cnt_d   = hit_cnt_q + CNT_ONE;
          end else if (!cpu_we_i) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = cpu_word_addr;
            state_d    = ST_REFILL;
          end else begin
            // Write-through: refresh the line only if present, never allocate.
            wr_en       = arr_hit;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cpu_word_addr;
            mem_wdata_d = cpu_wdata_i;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_REFILL: begin
        if (mem_ack_i) begin
          fill_en     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata_i;
          mem_req_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack_i) begin
          rsp_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        clr_en = 1'b1;
        if (flush_idx_q == IDX_LAST) begin
          flush_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + IDX_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      flush_idx_q  <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      flush_idx_q  <= flush_idx_d;
      flush_busy_q <= flush_busy_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
  assign flush_busy_o = flush_busy_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, flush and reset corner
// sequences, then random traffic against a transaction-level cache model.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid_i, cpu_ready_o, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        flush_i, flush_busy_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] hit_count_o, miss_count_o;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // ---------------- backing memory ----------------
  logic [31:0] mem_model [logic [31:0]];
  int          mem_lat = 0;
  int          acks = 0;
  int          wait_cnt = 0;
  int          req_cycles_cur = 0;
  int          last_req_cycles = 0;
  logic [31:0] last_addr, last_wdata;
  logic        last_we;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !mem_req_o) begin
      mem_ack_i      = 1'b0;
      mem_rdata_i    = $urandom;
      wait_cnt       = 0;
      req_cycles_cur = 0;
    end else begin
      req_cycles_cur++;
      if (wait_cnt >= mem_lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_rd(mem_addr_o);
        if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
        acks++;
        last_addr       = mem_addr_o;
        last_we         = mem_we_o;
        last_wdata      = mem_wdata_o;
        last_req_cycles = req_cycles_cur;
        req_cycles_cur  = 0;
        wait_cnt        = 0;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        wait_cnt++;
      end
    end
  end

  // ---------------- reference cache model ----------------
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];
  int          m_hits = 0;
  int          m_miss = 0;

  task automatic model_clear(input bit counters);
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    if (counters) begin
      m_hits = 0;
      m_miss = 0;
    end
  endtask

  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic hit, output logic [31:0] rdata);
    int idx;
    logic [21:0] tag;
    idx   = int'((addr >> 2) & 32'hFF);
    tag   = addr[31:10];
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    rdata = '0;
    if (!we) begin
      if (hit) begin
        rdata = m_data[idx];
        m_hits++;
      end else begin
        rdata        = mem_rd(addr & ~32'h3);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_data[idx]  = rdata;
        m_miss++;
      end
    end else if (hit) begin
      m_data[idx] = wdata;
    end
  endtask

  // ---------------- CPU transaction driver ----------------
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat, output int nacc);
    int a0;
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
    chk("ready_idle", 32'(cpu_ready_o), 32'd1);
    a0 = acks;
    cpu_valid_i = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    @(negedge clk);
    cpu_valid_i = 1'b0;
    cpu_we_i    = 1'(($urandom));
    cpu_addr_i  = $urandom;
    cpu_wdata_i = $urandom;
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 32'd0, 32'd1);
    rdata = rsp_rdata_o;
    nacc  = acks - a0;
  endtask

  task automatic check_op(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                          input int nacc, input logic [31:0] exp_rdata, input int exp_lat,
                          input int exp_acc, input int exp_hits, input int exp_miss);
    $display("%s we=%0d addr=%08h rdata=%08h lat=%0d mem=%0d hits=%0d misses=%0d",
             nm, we, addr, rdata, lat, nacc, hit_count_o, miss_count_o);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_mem_accesses"}, 32'(nacc), 32'(exp_acc));
    if (!we) chk({nm, "_rdata"}, rdata, exp_rdata);
    if (exp_acc == 1) begin
      chk({nm, "_mem_addr"}, last_addr, addr & ~32'h3);
      chk({nm, "_mem_we"}, 32'(last_we), 32'(we));
      chk({nm, "_req_cycles"}, 32'(last_req_cycles), 32'(mem_lat + 1));
      if (we) chk({nm, "_mem_wdata"}, last_wdata, wdata);
    end
    chk({nm, "_hit_count"}, hit_count_o, 32'(exp_hits));
    chk({nm, "_miss_count"}, miss_count_o, 32'(exp_miss));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_acc;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, exp_rd;
    logic        exp_hit, mhit;
    int          lat, nacc, busy_cycles, rsp_seen;

    tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 4, 1, 0, 1};
    tbl[1]  = '{1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1, 0, 1, 1};
    tbl[2]  = '{1'b0, 32'h0000_0500, 32'h0, 1, 32'hCAFE_F00D, 3, 1, 1, 2};
    tbl[3]  = '{1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 2, 1, 1, 3};
    tbl[4]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 1, 32'h0, 3, 1, 1, 3};
    tbl[5]  = '{1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678, 1, 0, 2, 3};
    tbl[6]  = '{1'b1, 32'h0000_0200, 32'h55AA_55AA, 0, 32'h0, 2, 1, 2, 3};
    tbl[7]  = '{1'b0, 32'h0000_0200, 32'h0, 1, 32'h55AA_55AA, 3, 1, 2, 4};
    tbl[8]  = '{1'b0, 32'h0000_0203, 32'h0, 0, 32'h55AA_55AA, 1, 0, 3, 4};
    tbl[9]  = '{1'b0, 32'h0000_0502, 32'h0, 0, 32'hCAFE_F00D, 2, 1, 3, 5};
    tbl[10] = '{1'b1, 32'h0000_0501, 32'hAAAA_0001, 3, 32'h0, 5, 1, 3, 5};
    tbl[11] = '{1'b0, 32'h0000_0500, 32'h0, 0, 32'hAAAA_0001, 1, 0, 4, 5};

    mem_model[32'h0000_0100] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0500] = 32'hCAFE_F00D;
    mem_model[32'h0000_0200] = 32'h0BAD_F00D;

    rst_n = 1'b0; cpu_valid_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("reset_mem_we", 32'(mem_we_o), 32'd0);
    chk("reset_mem_addr", mem_addr_o, 32'd0);
    chk("reset_mem_wdata", mem_wdata_o, 32'd0);
    chk("reset_hits", hit_count_o, 32'd0);
    chk("reset_misses", miss_count_o, 32'd0);
    chk("reset_flush_busy", 32'(flush_busy_o), 32'd0);
    rst_n = 1'b1;
    model_clear(1'b1);

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 12; i++) begin
      mem_lat = tbl[i].lat;
      model_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, mhit, exp_rd);
      do_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, rdata, lat, nacc);
      check_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, rdata, lat, nacc,
               tbl[i].exp_rdata, tbl[i].exp_lat, tbl[i].exp_acc, tbl[i].exp_hits,
               tbl[i].exp_miss);
    end

    // Flush requested together with a CPU request: flush wins, lasts 256 cycles.
    @(negedge clk);
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100; flush_i = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(cpu_ready_o), 32'd0);
    @(negedge clk);
    cpu_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_ready_low", 32'(cpu_ready_o), 32'd0);
    busy_cycles = 0;
    rsp_seen = 0;
    while (flush_busy_o && busy_cycles < 1000) begin
      busy_cycles++;
      if (rsp_valid_o || mem_req_o) rsp_seen = 1;
      flush_i = (busy_cycles == 100);
      @(negedge clk);
    end
    flush_i = 1'b0;
    $display("flush busy_cycles=%0d", busy_cycles);
    chk("flush_busy_cycles", 32'(busy_cycles), 32'd256);
    chk("flush_quiet", 32'(rsp_seen), 32'd0);
    model_clear(1'b0);
    mem_lat = 1;
    model_op(1'b0, 32'h0000_0100, 32'h0, mhit, exp_rd);
    do_op(1'b0, 32'h0000_0100, 32'h0, rdata, lat, nacc);
    check_op("post_flush", 1'b0, 32'h0000_0100, 32'h0, rdata, lat, nacc,
             32'h1234_5678, 3, 1, m_hits, m_miss);

    // Random traffic over a small address pool so hits, misses and aliasing all occur.
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] addr, wdata;
      we      = ($urandom_range(0, 3) == 0);
      addr    = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
      wdata   = $urandom;
      mem_lat = $urandom_range(0, 3);
      model_op(we, addr, wdata, exp_hit, exp_rd);
      do_op(we, addr, wdata, rdata, lat, nacc);
      check_op($sformatf("rnd%0d", i), we, addr, wdata, rdata, lat, nacc, exp_rd,
               (!we && exp_hit) ? 1 : mem_lat + 2, (!we && exp_hit) ? 0 : 1, m_hits, m_miss);
    end

    // Reset in the middle of a refill aborts it silently.
    mem_lat = 20;
    @(negedge clk);
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hABC0_0100;
    @(negedge clk);
    cpu_valid_i = 1'b0;
    chk("refill_req_high", 32'(mem_req_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_req", 32'(mem_req_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_o || mem_req_o) rsp_seen = 1;
    end
    $display("reset_abort rsp_or_req_seen=%0d hits=%0d misses=%0d", rsp_seen, hit_count_o,
             miss_count_o);
    chk("reset_abort_quiet", 32'(rsp_seen), 32'd0);
    chk("reset_abort_hits", hit_count_o, 32'd0);
    chk("reset_abort_misses", miss_count_o, 32'd0);
    model_clear(1'b1);
    mem_lat = 1;
    model_op(1'b0, 32'h0000_0100, 32'h0, mhit, exp_rd);
    do_op(1'b0, 32'h0000_0100, 32'h0, rdata, lat, nacc);
    check_op("post_reset", 1'b0, 32'h0000_0100, 32'h0, rdata, lat, nacc, exp_rd, 3, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
